// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types for the sequential shift unit
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_ROR = 2'b10,
        SH_LSL = 2'b11
    } shmode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } shstate_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-position shifter for all four modes
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_i,
    input  shmode_t          mode_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (mode_i)
            SH_LSR:  data_o = {1'b0, data_i[WIDTH-1:1]};
            SH_ASR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            SH_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            SH_LSL:  data_o = {data_i[WIDTH-2:0], 1'b0};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/seq_rshifter4.sv
// rtl/seq_rshifter4.sv - multi-cycle shifter, one bit position per clock
module seq_rshifter4
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [NW-1:0]    amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    shstate_t         state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [NW-1:0]    cnt_q;
    shmode_t          mreg_q;
    logic [WIDTH-1:0] dout_q;
    logic             done_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i (sreg_q),
        .mode_i (mreg_q),
        .data_o (sreg_d)
    );

    // dout is loaded on the edge that enters FINISH so it is valid alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            mreg_q  <= SH_LSR;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sreg_q <= din;
                        cnt_q  <= amt;
                        mreg_q <= shmode_t'(mode);
                        if (amt == '0) begin
                            state_q <= ST_FINISH;
                            dout_q  <= din;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    sreg_q <= sreg_d;
                    cnt_q  <= cnt_q - NW'(1);
                    if (cnt_q == NW'(1)) begin
                        state_q <= ST_FINISH;
                        dout_q  <= sreg_d;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule
